// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and sizing helpers for the UART transmitter arbiter.
// The requester index is sized for the largest supported requester count.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      ACK,
      XMIT
   } arb_state_t;

   localparam int NREQ_MAX = 8;
   localparam int IDX_W    = $clog2(NREQ_MAX);

   function automatic int tmo_cnt_w(input int timeout);
      return $clog2(timeout);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping, so the previous winner is considered last.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   genvar gi;

   // Walk from the farthest candidate to the nearest so the nearest one wins.
   always_comb begin
      o_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (i_req[(int'(i_ptr) + k) % NREQ]) begin
            o_idx = IDX_W'((int'(i_ptr) + k) % NREQ);
         end
      end
   end

   assign o_any = |i_req;

   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_onehot
         assign o_grant[gi] = o_any && (o_idx == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one UART transmitter between
// NREQ byte-stream requesters; a stalled owner loses its lock after TIMEOUT.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req_valid,
   input  logic [8*NREQ-1:0] i_req_data,
   input  logic [NREQ-1:0]   i_req_last,
   output logic [NREQ-1:0]   o_req_ready,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_start,
   input  logic              i_tx_busy,
   output logic [NREQ-1:0]   o_grant,
   output logic              o_timeout_evt
);

   localparam int               CNT_W    = tmo_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   genvar gi;

   arb_state_t       r_state,    w_state_next;
   logic [NREQ-1:0]  r_grant,    w_grant_next;
   logic [IDX_W-1:0] r_owner,    w_owner_next;
   logic [IDX_W-1:0] r_ptr,      w_ptr_next;
   logic [CNT_W-1:0] r_cnt,      w_cnt_next;
   logic [7:0]       r_tx_data,  w_tx_data_next;
   logic             r_tx_start, w_tx_start_next;
   logic             r_evt,      w_evt_next;
   logic             r_last,     w_last_next;

   logic [NREQ-1:0]  w_pick_grant;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_pick_any;
   logic             w_owner_valid;
   logic [7:0]       w_owner_data;
   logic             w_owner_last;
   logic             w_xfer;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   // Only the owner can be ready, and never while a frame is still going out.
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_ready
         assign o_req_ready[gi] = (r_state == ISSUE) && r_grant[gi] &&
                                  i_req_valid[gi] && !i_tx_busy;
      end
   endgenerate

   assign w_xfer        = |o_req_ready;
   assign w_owner_valid = |(i_req_valid & r_grant);

   always_comb begin
      w_owner_data = '0;
      w_owner_last = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (r_grant[k]) begin
            w_owner_data = i_req_data[8*k +: 8];
            w_owner_last = i_req_last[k];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_owner    <= '0;
         r_ptr      <= IDX_W'(NREQ - 1);
         r_cnt      <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_evt      <= 1'b0;
         r_last     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_grant    <= w_grant_next;
         r_owner    <= w_owner_next;
         r_ptr      <= w_ptr_next;
         r_cnt      <= w_cnt_next;
         r_tx_data  <= w_tx_data_next;
         r_tx_start <= w_tx_start_next;
         r_evt      <= w_evt_next;
         r_last     <= w_last_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_grant_next    = r_grant;
      w_owner_next    = r_owner;
      w_ptr_next      = r_ptr;
      w_cnt_next      = r_cnt;
      w_tx_data_next  = r_tx_data;
      w_tx_start_next = 1'b0;
      w_evt_next      = 1'b0;
      w_last_next     = r_last;
      case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (w_pick_any) begin
               w_grant_next = w_pick_grant;
               w_owner_next = w_pick_idx;
               w_state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (w_xfer) begin
               w_tx_data_next  = w_owner_data;
               w_tx_start_next = 1'b1;
               w_last_next     = w_owner_last;
               w_cnt_next      = '0;
               w_state_next    = ACK;
            end else if (!w_owner_valid) begin
               // Stall timer only runs while the owner has nothing to offer.
               if (r_cnt == CNT_LAST) begin
                  w_grant_next = '0;
                  w_evt_next   = 1'b1;
                  w_ptr_next   = r_owner;
                  w_cnt_next   = '0;
                  w_state_next = IDLE;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
         ACK: begin
            w_state_next = XMIT;
         end
         XMIT: begin
            if (!i_tx_busy) begin
               if (r_last) begin
                  w_grant_next = '0;
                  w_ptr_next   = r_owner;
                  w_state_next = IDLE;
               end else begin
                  w_state_next = ISSUE;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign o_grant       = r_grant;
   assign o_tx_data     = r_tx_data;
   assign o_tx_start    = r_tx_start;
   assign o_timeout_evt = r_evt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue requesters, a fixed-length busy
// transmitter model and a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic [NREQ-1:0]   grant;
   logic              timeout_evt;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req_valid   (req_valid),
      .i_req_data    (req_data),
      .i_req_last    (req_last),
      .o_req_ready   (req_ready),
      .o_tx_data     (tx_data),
      .o_tx_start    (tx_start),
      .i_tx_busy     (tx_busy),
      .o_grant       (grant),
      .o_timeout_evt (timeout_evt)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Per-requester byte queues, entries are {last, data}.
   logic [8:0] rq [NREQ][$];
   bit         en [NREQ];
   int         busy_len   = 10;
   int         busy_cnt   = 0;
   bit         force_busy = 1'b0;

   logic [NREQ-1:0] s_ready, s_grant;
   logic            s_start, s_evt, s_busy;
   logic [7:0]      s_data;
   int              s_cyc;

   int         log_own [$];
   logic [7:0] log_dat [$];
   int         exp_own [$];
   logic [7:0] exp_dat [$];
   int         m_ptr;

   function automatic int owner_of(input logic [NREQ-1:0] g);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (g === (NREQ'(1) << i)) r = i;
      return r;
   endfunction

   function automatic bit queues_empty();
      bit e = 1'b1;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (en[i] && rq[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
      tx_busy = (busy_cnt > 0) || force_busy;
   endtask

   // One clock: sample mid-cycle, then apply transfers and the transmitter.
   task automatic tick();
      logic [NREQ-1:0] xfer;
      @(negedge clk);
      s_cyc   = cyc;
      s_ready = req_ready;
      s_grant = grant;
      s_start = tx_start;
      s_evt   = timeout_evt;
      s_busy  = tx_busy;
      s_data  = tx_data;
      if (s_start) begin
         log_own.push_back(owner_of(s_grant));
         log_dat.push_back(s_data);
         total++;
         if (s_busy !== 1'b0) begin
            bad++;
            $display("FAIL start_while_busy: cycle %0d tx_busy=%b required 0", s_cyc, s_busy);
         end
      end
      xfer = req_valid & s_ready;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NREQ; i++) if (xfer[i]) rq[i].delete(0);
      if (s_start) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      drive();
   endtask

   task automatic drain(input int bound, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < bound; n++) begin
         tick();
         if (queues_empty() && busy_cnt == 0 && grant == '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Whole packets, owners visited round-robin after the last packet owner.
   task automatic build_expected();
      logic [8:0] cp [NREQ][$];
      int  p;
      bit  found;
      for (int i = 0; i < NREQ; i++) cp[i] = rq[i];
      exp_own.delete();
      exp_dat.delete();
      p     = m_ptr;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int k = 1; k <= NREQ && !found; k++) begin
            int j = (p + k) % NREQ;
            if (cp[j].size() > 0) begin
               bit done = 1'b0;
               while (!done && cp[j].size() > 0) begin
                  exp_own.push_back(j);
                  exp_dat.push_back(cp[j][0][7:0]);
                  done = cp[j][0][8];
                  cp[j].delete(0);
               end
               p     = j;
               found = 1'b1;
            end
         end
      end
      m_ptr = p;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         en[i] = 1'b1;
         rq[i].delete();
      end
      rq[0].push_back({1'b1, 8'h99});
      drive();
      tick();
      tick();
      total++; if (s_grant !== '0) begin bad++; $display("FAIL reset_grant: got %b want 0", s_grant); end
      total++; if (s_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", s_ready); end
      total++; if (s_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", s_start); end
      total++; if (s_evt !== 1'b0) begin bad++; $display("FAIL reset_evt: got %b want 0", s_evt); end
      total++; if (s_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", s_data); end
      rq[0].delete();
      drive();
      m_ptr = NREQ - 1;
   endtask

   task automatic test_contention();
      bit ok;
      busy_len = 4;
      for (int ph = 0; ph < 2; ph++) begin
         log_own.delete();
         log_dat.delete();
         if (ph == 0) begin
            rq[0].push_back({1'b0, 8'hA0}); rq[0].push_back({1'b1, 8'hA1});
            rq[1].push_back({1'b0, 8'hB0}); rq[1].push_back({1'b1, 8'hB1});
         end else begin
            rq[0].push_back({1'b1, 8'hC0});
            rq[1].push_back({1'b1, 8'hD0});
         end
         build_expected();
         drive();
         if (ph == 0) rst = 1'b0;
         drain(500, ok);
         total++; if (!ok) begin bad++; $display("FAIL contention_drain: phase %0d timed out", ph); end
         total++;
         if (log_dat.size() != exp_dat.size()) begin
            bad++;
            $display("FAIL contention_count: phase %0d got %0d bytes want %0d", ph, log_dat.size(), exp_dat.size());
         end
         for (int k = 0; k < exp_dat.size() && k < log_dat.size(); k++) begin
            total++;
            if (log_dat[k] !== exp_dat[k] || log_own[k] != exp_own[k]) begin
               bad++;
               $display("FAIL contention_byte: phase %0d #%0d got req%0d %h want req%0d %h",
                        ph, k, log_own[k], log_dat[k], exp_own[k], exp_dat[k]);
            end
         end
      end
   endtask

   task automatic test_single();
      int t0, g1, gz, last_busy;
      int starts [$];
      bit gbad;
      logic [7:0] want [3];
      want[0] = 8'h41; want[1] = 8'h42; want[2] = 8'h43;
      busy_len = 10;
      log_own.delete();
      log_dat.delete();
      for (int k = 0; k < 3; k++) rq[0].push_back({k == 2, want[k]});
      drive();
      t0 = cyc; g1 = -1; gz = -1; last_busy = -1; gbad = 1'b0;
      for (int n = 0; n < 200 && gz < 0; n++) begin
         tick();
         if (s_start) starts.push_back(s_cyc);
         if (s_busy) last_busy = s_cyc;
         if (g1 < 0 && s_grant != '0) g1 = s_cyc;
         if (g1 >= 0) begin
            if (starts.size() == 3 && s_grant == '0) gz = s_cyc;
            else if (s_grant !== 2'b01) gbad = 1'b1;
         end
      end
      total++; if (g1 != t0 + 1) begin bad++; $display("FAIL single_grant_lat: got cycle %0d want %0d", g1, t0 + 1); end
      total++;
      if (starts.size() != 3) begin
         bad++;
         $display("FAIL single_starts: got %0d pulses want 3", starts.size());
      end else begin
         total++; if (starts[0] != t0 + 2) begin bad++; $display("FAIL single_start_lat: got %0d want %0d", starts[0], t0 + 2); end
         for (int k = 1; k < 3; k++) begin
            total++;
            if (starts[k] - starts[k-1] != busy_len + 3) begin
               bad++;
               $display("FAIL single_spacing: byte %0d gap %0d want %0d", k, starts[k] - starts[k-1], busy_len + 3);
            end
         end
         for (int k = 0; k < 3; k++) begin
            total++;
            if (log_dat[k] !== want[k] || log_own[k] != 0) begin
               bad++;
               $display("FAIL single_byte: #%0d got req%0d %h want req0 %h", k, log_own[k], log_dat[k], want[k]);
            end
         end
      end
      total++; if (gbad) begin bad++; $display("FAIL single_grant_held: grant left 01 during packet, want 01"); end
      total++; if (gz != last_busy + 2) begin bad++; $display("FAIL single_release: grant 0 at %0d want %0d", gz, last_busy + 2); end
      m_ptr = 0;
   endtask

   task automatic test_intrusion();
      int g10;
      bit done;
      logic [7:0] want [5];
      want[0] = 8'hD0; want[1] = 8'hD1; want[2] = 8'hD2; want[3] = 8'hD3; want[4] = 8'hE0;
      busy_len = 3;
      log_own.delete();
      log_dat.delete();
      for (int k = 0; k < 4; k++) rq[0].push_back({k == 3, want[k]});
      rq[1].push_back({1'b1, 8'hE0});
      en[1] = 1'b0;
      drive();
      g10 = -1; done = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         tick();
         if (en[1] && s_grant == 2'b01) begin
            total++;
            if (s_ready[1] !== 1'b0) begin bad++; $display("FAIL intrusion_ready1: cycle %0d got %b want 0", s_cyc, s_ready[1]); end
         end
         if (g10 < 0 && s_grant == 2'b10) g10 = s_cyc;
         if (!en[1] && log_dat.size() >= 2) begin
            en[1] = 1'b1;
            drive();
         end
         done = (log_dat.size() == 5) && queues_empty() && busy_cnt == 0 && grant == '0;
      end
      total++; if (!done) begin bad++; $display("FAIL intrusion_drain: got %0d bytes want 5", log_dat.size()); end
      total++; if (g10 < 0) begin bad++; $display("FAIL intrusion_handover: grant 10 never seen, want 10"); end
      for (int k = 0; k < 5 && k < log_dat.size(); k++) begin
         total++;
         if (log_dat[k] !== want[k] || log_own[k] != (k == 4 ? 1 : 0)) begin
            bad++;
            $display("FAIL intrusion_byte: #%0d got req%0d %h want req%0d %h", k, log_own[k], log_dat[k], (k == 4 ? 1 : 0), want[k]);
         end
      end
      m_ptr = 1;
   endtask

   task automatic test_timeout();
      int st, fall, evt_c, evt_n;
      logic [NREQ-1:0] g_evt, g_after;
      bit done;
      busy_len = 3;
      log_own.delete();
      log_dat.delete();
      rq[0].push_back({1'b0, 8'h55});
      rq[1].push_back({1'b1, 8'h66});
      drive();
      st = -1; fall = -1; evt_c = -1; evt_n = 0; g_evt = 'x; g_after = 'x; done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         tick();
         if (st < 0 && s_start) st = s_cyc;
         if (st >= 0 && fall < 0 && s_cyc > st && !s_busy) fall = s_cyc;
         if (evt_c >= 0 && s_cyc == evt_c + 1) g_after = s_grant;
         if (s_evt) begin
            evt_n++;
            if (evt_c < 0) begin evt_c = s_cyc; g_evt = s_grant; end
         end
         done = (log_dat.size() == 2) && queues_empty() && busy_cnt == 0 && grant == '0;
      end
      total++; if (!done) begin bad++; $display("FAIL timeout_drain: got %0d bytes want 2", log_dat.size()); end
      total++; if (evt_c - fall != TIMEOUT + 1) begin bad++; $display("FAIL timeout_issue_cycles: got %0d want %0d", evt_c - fall - 1, TIMEOUT); end
      total++; if (evt_n != 1) begin bad++; $display("FAIL timeout_pulses: got %0d want 1", evt_n); end
      total++; if (g_evt !== 2'b00) begin bad++; $display("FAIL timeout_grant_drop: got %b want 00", g_evt); end
      total++; if (g_after !== 2'b10) begin bad++; $display("FAIL timeout_regrant: got %b want 10", g_after); end
      total++;
      if (log_dat.size() != 2 || log_dat[0] !== 8'h55 || log_dat[1] !== 8'h66 || log_own[0] != 0 || log_own[1] != 1) begin
         bad++;
         $display("FAIL timeout_bytes: got %0d bytes, want req0 55 then req1 66", log_dat.size());
      end
      m_ptr = 1;
   endtask

   task automatic test_reset_xmit();
      logic [NREQ-1:0] g_pre, g_first;
      bit ok;
      busy_len = 10;
      log_own.delete();
      log_dat.delete();
      rq[0].push_back({1'b0, 8'hC1});
      rq[0].push_back({1'b1, 8'hC2});
      drive();
      for (int n = 0; n < 20 && log_dat.size() == 0; n++) tick();
      tick();
      tick();
      g_pre = grant;
      total++; if (g_pre !== 2'b01 || tx_busy !== 1'b1) begin bad++; $display("FAIL rstx_precond: grant %b busy %b want 01 1", g_pre, tx_busy); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (grant !== '0) begin bad++; $display("FAIL rstx_grant: got %b want 0", grant); end
      total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rstx_start: got %b want 0", tx_start); end
      total++; if (req_ready !== '0) begin bad++; $display("FAIL rstx_ready: got %b want 0", req_ready); end
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      m_ptr = NREQ - 1;
      log_own.delete();
      log_dat.delete();
      drive();
      tick();
      tick();
      rst = 1'b0;
      rq[0].push_back({1'b1, 8'h11});
      rq[1].push_back({1'b1, 8'h22});
      build_expected();
      drive();
      g_first = '0;
      for (int n = 0; n < 10 && g_first == '0; n++) begin
         tick();
         g_first = s_grant;
      end
      total++; if (g_first !== 2'b01) begin bad++; $display("FAIL rstx_first_grant: got %b want 01", g_first); end
      drain(500, ok);
      total++; if (!ok) begin bad++; $display("FAIL rstx_drain: timed out"); end
      total++;
      if (log_dat.size() != exp_dat.size()) begin
         bad++;
         $display("FAIL rstx_count: got %0d bytes want %0d", log_dat.size(), exp_dat.size());
      end
      for (int k = 0; k < exp_dat.size() && k < log_dat.size(); k++) begin
         total++;
         if (log_dat[k] !== exp_dat[k] || log_own[k] != exp_own[k]) begin
            bad++;
            $display("FAIL rstx_byte: #%0d got req%0d %h want req%0d %h", k, log_own[k], log_dat[k], exp_own[k], exp_dat[k]);
         end
      end
   endtask

   task automatic test_busy_stuck();
      bit found, ok;
      busy_len = 4;
      force_busy = 1'b1;
      en[1] = 1'b0;
      log_own.delete();
      log_dat.delete();
      rq[0].push_back({1'b1, 8'h77});
      drive();
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         tick();
         found = (s_grant == 2'b01);
      end
      total++; if (!found) begin bad++; $display("FAIL stuck_grant: grant never 01"); end
      for (int n = 0; n < TIMEOUT + 4; n++) begin
         tick();
         total++;
         if (s_ready[0] !== 1'b0 || s_start !== 1'b0 || s_evt !== 1'b0) begin
            bad++;
            $display("FAIL stuck_hold: cycle %0d ready %b start %b evt %b want 0 0 0", s_cyc, s_ready[0], s_start, s_evt);
         end
      end
      force_busy = 1'b0;
      drive();
      tick();
      total++; if (s_ready[0] !== 1'b1) begin bad++; $display("FAIL stuck_release_ready: got %b want 1", s_ready[0]); end
      tick();
      total++; if (s_start !== 1'b1 || s_data !== 8'h77) begin bad++; $display("FAIL stuck_release_start: start %b data %h want 1 77", s_start, s_data); end
      drain(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL stuck_drain: timed out"); end
      en[1] = 1'b1;
      drive();
      m_ptr = 0;
   endtask

   task automatic test_random();
      bit ok;
      for (int r = 0; r < 6; r++) begin
         busy_len = $urandom_range(1, 6);
         log_own.delete();
         log_dat.delete();
         for (int i = 0; i < NREQ; i++) begin
            int npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
               int len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++) rq[i].push_back({b == len - 1, 8'($urandom)});
            end
         end
         build_expected();
         drive();
         drain(2000, ok);
         total++; if (!ok) begin bad++; $display("FAIL random_drain: round %0d timed out", r); end
         total++;
         if (log_dat.size() != exp_dat.size()) begin
            bad++;
            $display("FAIL random_count: round %0d got %0d bytes want %0d", r, log_dat.size(), exp_dat.size());
         end
         for (int k = 0; k < exp_dat.size() && k < log_dat.size(); k++) begin
            total++;
            if (log_dat[k] !== exp_dat[k] || log_own[k] != exp_own[k]) begin
               bad++;
               $display("FAIL random_byte: round %0d #%0d got req%0d %h want req%0d %h",
                        r, k, log_own[k], log_dat[k], exp_own[k], exp_dat[k]);
            end
         end
      end
   endtask

   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;
      rst       = 1'b1;
      test_reset();
      test_contention();
      test_single();
      test_intrusion();
      test_timeout();
      test_reset_xmit();
      test_busy_stuck();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
